// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizing for the two-port SDRAM arbiter.
// No logic; pure declarations.
// No flow control; consumed by sdram_arbiter and sdram_arb_tag_fifo.
package sdram_arb_pkg;

    // Arbiter ownership states: nobody, port 0 or port 1 holds the grant.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Identifies an issuing port; stored per outstanding read.
    typedef logic port_id_t;

    localparam int ADDR_W_DFLT   = 25;
    localparam int DATA_W_DFLT   = 16;
    localparam int HOLD_MAX_DFLT = 8;
    localparam int MAX_PEND_DFLT = 8;

    // Ownership state that corresponds to a given port.
    function automatic arb_state_t own_state(input port_id_t id);
        return id ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO: remembers which port issued each outstanding SDRAM read, in issue order.
// Head is combinational from storage; push/pop take effect on the next clock.
// Push is dropped when full unless a pop happens in the same cycle; pop on empty is ignored.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter  int DEPTH = MAX_PEND_DFLT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  port_id_t         push_dat,
    input  logic             pop_vld,
    output port_id_t         head_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    port_id_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop_vld & ~empty;
    // A slot freed by this cycle's pop can be refilled in the same cycle.
    assign do_push  = push_vld & (~full | do_pop);
    assign head_dat = mem[rd_ptr];

    // Tag storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM controller between two masters, with read-return routing.
// 1 cycle grant latency from IDLE; commands then pass through combinationally; read data routing is combinational.
// Owner sees the controller's waitrequest; the other port is held; reads stall while MAX_PEND reads are outstanding.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DFLT,
    parameter int DATA_W   = DATA_W_DFLT,
    parameter int HOLD_MAX = HOLD_MAX_DFLT,
    parameter int MAX_PEND = MAX_PEND_DFLT
) (
    input  logic                clk_clk,
    input  logic                reset_reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,

    output logic                arb_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_PEND) + 1;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdat;
        logic [BE_W-1:0]   be;
    } cmd_t;

    arb_state_t       state;
    logic [7:0]       hold_cnt;
    logic [8:0]       hold_inc;
    port_id_t         last_served;
    port_id_t         own_id;
    port_id_t         oth_id;
    logic             owned;

    cmd_t             m_cmd [2];
    cmd_t             fwd_cmd;
    logic [1:0]       req;
    logic [1:0]       cmd_any;
    logic             rd_ok;
    logic             accept;

    logic             tag_push_vld;
    logic             tag_full;
    logic             tag_empty;
    port_id_t         tag_head_dat;
    logic [CNT_W-1:0] tag_count;

    // Read+write together is a protocol error; the read wins.
    assign m_cmd[0] = '{rd: m0_read, wr: m0_write & ~m0_read, addr: m0_address,
                        wdat: m0_writedata, be: m0_byteenable};
    assign m_cmd[1] = '{rd: m1_read, wr: m1_write & ~m1_read, addr: m1_address,
                        wdat: m1_writedata, be: m1_byteenable};

    // A returning read frees its tag slot in the same cycle, so a waiting read may go.
    assign rd_ok = ~tag_full | s_readdatavalid;

    assign cmd_any[0] = m_cmd[0].rd | m_cmd[0].wr;
    assign cmd_any[1] = m_cmd[1].rd | m_cmd[1].wr;
    assign req[0]     = m_cmd[0].wr | (m_cmd[0].rd & rd_ok);
    assign req[1]     = m_cmd[1].wr | (m_cmd[1].rd & rd_ok);

    assign owned   = (state != IDLE);
    assign own_id  = (state == OWN1);
    assign oth_id  = ~own_id;
    assign fwd_cmd = m_cmd[own_id];

    assign s_address    = fwd_cmd.addr;
    assign s_writedata  = fwd_cmd.wdat;
    assign s_byteenable = fwd_cmd.be;
    assign s_read       = owned & fwd_cmd.rd & rd_ok;
    assign s_write      = owned & fwd_cmd.wr;
    assign accept       = (s_read | s_write) & ~s_waitrequest;

    // A held-off read must see waitrequest even when the controller is ready.
    assign m0_waitrequest = (state != OWN0) | s_waitrequest | (m_cmd[0].rd & ~rd_ok);
    assign m1_waitrequest = (state != OWN1) | s_waitrequest | (m_cmd[1].rd & ~rd_ok);

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = s_readdatavalid & ~tag_empty & (tag_head_dat == 1'b0);
    assign m1_readdatavalid = s_readdatavalid & ~tag_empty & (tag_head_dat == 1'b1);

    assign hold_inc     = {1'b0, hold_cnt} + 9'd1;
    assign tag_push_vld = s_read & ~s_waitrequest;

    sdram_arb_tag_fifo #(
        .DEPTH (MAX_PEND)
    ) u_tag_fifo (
        .clk      (clk_clk),
        .rst      (reset_reset),
        .push_vld (tag_push_vld),
        .push_dat (own_id),
        .pop_vld  (s_readdatavalid),
        .head_dat (tag_head_dat),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    // Grant FSM: round-robin on ties, hand over on owner idle or hold expiry, never mid-command.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (req[0] && req[1]) begin
                        state <= last_served ? OWN0 : OWN1;
                    end else if (req[0]) begin
                        state <= OWN0;
                    end else if (req[1]) begin
                        state <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    if (!req[own_id] && req[oth_id]) begin
                        state       <= own_state(oth_id);
                        hold_cnt    <= '0;
                        last_served <= own_id;
                    end else if (!cmd_any[own_id] && !req[oth_id]) begin
                        state       <= IDLE;
                        hold_cnt    <= '0;
                        last_served <= own_id;
                    end else if (accept) begin
                        if ((hold_inc >= 9'(HOLD_MAX)) && req[oth_id]) begin
                            state       <= own_state(oth_id);
                            hold_cnt    <= '0;
                            last_served <= own_id;
                        end else if (hold_cnt != '1) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Sticky flag for read data that no outstanding read can claim.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            arb_err <= 1'b0;
        end else if (s_readdatavalid && (tag_count == '0)) begin
            arb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a queue-based reference model checked every cycle.
module tb_sdram_arbiter;

    localparam int ADDR_W   = 25;
    localparam int DATA_W   = 16;
    localparam int BE_W     = 2;
    localparam int HOLD_MAX = 8;
    localparam int MAX_PEND = 8;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
        logic [BE_W-1:0]   be;
    } cmd_s;

    logic clk_clk     = 1'b0;
    logic reset_reset = 1'b1;

    logic [ADDR_W-1:0] m_addr [2];
    logic              m_rd   [2];
    logic              m_wr   [2];
    logic [DATA_W-1:0] m_wdat [2];
    logic [BE_W-1:0]   m_be   [2];
    logic              m_wait [2];
    logic [DATA_W-1:0] m_rdat [2];
    logic              m_rdv  [2];

    logic [ADDR_W-1:0] s_address;
    logic              s_read;
    logic              s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [BE_W-1:0]   s_byteenable;
    logic              s_waitrequest;
    logic [DATA_W-1:0] s_readdata;
    logic              s_readdatavalid;
    logic              arb_err;

    always #5 clk_clk = ~clk_clk;

    sdram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX), .MAX_PEND(MAX_PEND)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .m0_address(m_addr[0]), .m0_read(m_rd[0]), .m0_write(m_wr[0]),
        .m0_writedata(m_wdat[0]), .m0_byteenable(m_be[0]), .m0_waitrequest(m_wait[0]),
        .m0_readdata(m_rdat[0]), .m0_readdatavalid(m_rdv[0]),
        .m1_address(m_addr[1]), .m1_read(m_rd[1]), .m1_write(m_wr[1]),
        .m1_writedata(m_wdat[1]), .m1_byteenable(m_be[1]), .m1_waitrequest(m_wait[1]),
        .m1_readdata(m_rdat[1]), .m1_readdatavalid(m_rdv[1]),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .arb_err(arb_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Master command queues; head is presented until the DUT accepts it.
    cmd_s q0[$];
    cmd_s q1[$];

    // Controller-side stimulus for the next cycle.
    logic              sw   = 1'b0;
    logic              rv   = 1'b0;
    logic [DATA_W-1:0] rdat = '0;

    // Reference model: owner 0/1, or 2 for nobody.
    int own;
    int hold;
    int last;
    int pend[$];
    bit err_m;

    // Logs and per-cycle snapshot of DUT outputs.
    int                acc_log[$];
    logic [DATA_W-1:0] rx0[$];
    logic [DATA_W-1:0] rx1[$];
    logic              snap_srd, snap_swr, snap_w0, snap_w1, snap_rdv0, snap_rdv1, snap_err;
    logic [ADDR_W-1:0] snap_addr;
    logic [DATA_W-1:0] snap_wdat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cmd_s mk_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                   input logic [BE_W-1:0] be);
        cmd_s c;
        c = '0;
        c.wr = 1'b1; c.addr = a; c.dat = d; c.be = be;
        return c;
    endfunction

    function automatic cmd_s mk_rd(input logic [ADDR_W-1:0] a);
        cmd_s c;
        c = '0;
        c.rd = 1'b1; c.addr = a; c.be = '1;
        return c;
    endfunction

    task automatic do_reset();
        reset_reset = 1'b1;
        q0.delete(); q1.delete();
        sw = 1'b0; rv = 1'b0;
        for (int p = 0; p < 2; p++) begin
            m_rd[p] = 1'b0; m_wr[p] = 1'b0; m_addr[p] = '0; m_wdat[p] = '0; m_be[p] = '0;
        end
        s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
        repeat (2) @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        own = 2; hold = 0; last = 1; pend.delete(); err_m = 1'b0;
        acc_log.delete(); rx0.delete(); rx1.delete();
    endtask

    // One clock: drive, compare against model, advance model and masters.
    task automatic cycle();
        cmd_s c [2];
        bit   pres [2];
        bit   rd [2];
        bit   wr [2];
        bit   req [2];
        bit   e_wait [2];
        bit   e_rdv [2];
        bit   dut_acc [2];
        bit   rdok, e_srd, e_swr, acc;
        int   o;
        pres[0] = (q0.size() > 0);
        pres[1] = (q1.size() > 0);
        c[0] = pres[0] ? q0[0] : '0;
        c[1] = pres[1] ? q1[0] : '0;
        for (int p = 0; p < 2; p++) begin
            m_rd[p] = c[p].rd; m_wr[p] = c[p].wr; m_addr[p] = c[p].addr;
            m_wdat[p] = c[p].dat; m_be[p] = c[p].be;
        end
        s_waitrequest = sw; s_readdatavalid = rv; s_readdata = rdat;
        #2;
        // Expected outputs from the arbitration rules.
        rdok = (pend.size() < MAX_PEND) || rv;
        for (int p = 0; p < 2; p++) begin
            rd[p]  = c[p].rd;
            wr[p]  = c[p].wr && !c[p].rd;
            req[p] = wr[p] || (rd[p] && rdok);
        end
        e_wait = '{1'b1, 1'b1};
        e_srd = 1'b0; e_swr = 1'b0; o = own;
        if (own != 2) begin
            e_srd     = rd[o] && rdok;
            e_swr     = wr[o];
            e_wait[o] = sw || (rd[o] && !rdok);
        end
        acc   = (e_srd || e_swr) && !sw;
        e_rdv = '{1'b0, 1'b0};
        if (rv && pend.size() > 0) e_rdv[pend[0]] = 1'b1;

        check("m0_waitrequest", m_wait[0], e_wait[0]);
        check("m1_waitrequest", m_wait[1], e_wait[1]);
        check("s_read", s_read, e_srd);
        check("s_write", s_write, e_swr);
        check("m0_readdatavalid", m_rdv[0], e_rdv[0]);
        check("m1_readdatavalid", m_rdv[1], e_rdv[1]);
        check("arb_err", arb_err, err_m);
        if (e_srd || e_swr) begin
            check("s_address", s_address, c[o].addr);
            check("s_byteenable", s_byteenable, c[o].be);
            if (e_swr) check("s_writedata", s_writedata, c[o].dat);
        end
        for (int p = 0; p < 2; p++) begin
            if (e_rdv[p]) check("m_readdata", m_rdat[p], rdat);
        end

        snap_srd = s_read; snap_swr = s_write; snap_w0 = m_wait[0]; snap_w1 = m_wait[1];
        snap_rdv0 = m_rdv[0]; snap_rdv1 = m_rdv[1]; snap_err = arb_err;
        snap_addr = s_address; snap_wdat = s_writedata;
        dut_acc[0] = pres[0] && !m_wait[0];
        dut_acc[1] = pres[1] && !m_wait[1];
        acc_log.push_back(dut_acc[0] ? 0 : (dut_acc[1] ? 1 : -1));
        if (m_rdv[0]) rx0.push_back(m_rdat[0]);
        if (m_rdv[1]) rx1.push_back(m_rdat[1]);

        @(posedge clk_clk);
        if (rv) begin
            if (pend.size() > 0) void'(pend.pop_front());
            else err_m = 1'b1;
        end
        if (acc && e_srd) pend.push_back(o);
        if (own == 2) begin
            hold = 0;
            if (req[0] && req[1]) own = (last == 0) ? 1 : 0;
            else if (req[0])      own = 0;
            else if (req[1])      own = 1;
        end else if (!req[o] && req[1-o]) begin
            last = o; own = 1 - o; hold = 0;
        end else if (!(rd[o] || wr[o]) && !req[1-o]) begin
            last = o; own = 2; hold = 0;
        end else if (acc) begin
            hold++;
            if (hold >= HOLD_MAX && req[1-o]) begin
                last = o; own = 1 - o; hold = 0;
            end
        end
        if (dut_acc[0]) void'(q0.pop_front());
        if (dut_acc[1]) void'(q1.pop_front());
        rv = 1'b0;
        #1;
    endtask

    initial begin
        int first;
        int nbad;
        int budget;

        do_reset();

        // Reset state.
        cycle();
        check("rst_w0", snap_w0, 1);
        check("rst_w1", snap_w1, 1);
        check("rst_sread", snap_srd, 0);
        check("rst_swrite", snap_swr, 0);
        check("rst_err", snap_err, 0);

        // Single port-0 write: one arbitration cycle, then forwarded.
        q0.push_back(mk_wr(25'h0000123, 16'hBEEF, 2'b11));
        cycle();
        check("t1_idle_swrite", snap_swr, 0);
        check("t1_idle_w0", snap_w0, 1);
        cycle();
        check("t1_fwd_swrite", snap_swr, 1);
        check("t1_fwd_addr", snap_addr, 25'h0000123);
        check("t1_fwd_wdata", snap_wdat, 16'hBEEF);
        check("t1_fwd_w0", snap_w0, 0);
        check("t1_fwd_w1", snap_w1, 1);
        repeat (2) cycle();

        // Both ports stream writes: runs of HOLD_MAX accepts, port 0 first, no gaps.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            q0.push_back(mk_wr(25'(i), 16'(16'h1000 + i), 2'b11));
            q1.push_back(mk_wr(25'(25'h100 + i), 16'(16'h2000 + i), 2'b11));
        end
        budget = 0;
        while ((q0.size() + q1.size()) > 0 && budget < 200) begin
            cycle();
            budget++;
        end
        check("t2_drained", q0.size() + q1.size(), 0);
        first = 0;
        while (first < acc_log.size() && acc_log[first] == -1) first++;
        check("t2_first_accept_cycle", first, 1);
        check("t2_log_len", (acc_log.size() >= first + 48) ? 1 : 0, 1);
        nbad = 0;
        for (int i = 0; i < 48 && (first + i) < acc_log.size(); i++) begin
            if (acc_log[first + i] != (i / 8) % 2) nbad++;
        end
        check("t2_run_pattern_errors", nbad, 0);

        // Interleaved reads routed back to their issuers.
        do_reset();
        q0.push_back(mk_rd(25'h10));
        q1.push_back(mk_rd(25'h20));
        repeat (3) cycle();
        q0.push_back(mk_rd(25'h30));
        repeat (3) cycle();
        check("t3_model_pending", pend.size(), 3);
        rdat = 16'hAAAA; rv = 1'b1; cycle();
        cycle();
        rdat = 16'hBBBB; rv = 1'b1; cycle();
        rdat = 16'hCCCC; rv = 1'b1; cycle();
        cycle();
        check("t3_rx0_count", rx0.size(), 2);
        check("t3_rx1_count", rx1.size(), 1);
        if (rx0.size() == 2) begin
            check("t3_rx0_first", rx0[0], 16'hAAAA);
            check("t3_rx0_second", rx0[1], 16'hCCCC);
        end
        if (rx1.size() == 1) check("t3_rx1_first", rx1[0], 16'hBBBB);
        check("t3_no_err", snap_err, 0);

        // Full tag FIFO: 9th read held, released on the cycle a read returns; writes unaffected.
        do_reset();
        for (int i = 0; i < 9; i++) q1.push_back(mk_rd(25'(25'h200 + i)));
        repeat (9) cycle();
        check("t4_model_pending", pend.size(), 8);
        cycle();
        check("t4_9th_w1", snap_w1, 1);
        check("t4_9th_sread", snap_srd, 0);
        cycle();
        check("t4_9th_w1_hold", snap_w1, 1);
        rdat = 16'h5A5A; rv = 1'b1; cycle();
        check("t4_release_sread", snap_srd, 1);
        check("t4_release_w1", snap_w1, 0);
        check("t4_release_rdv1", snap_rdv1, 1);
        q0.push_back(mk_wr(25'h300, 16'h1234, 2'b01));
        cycle();
        cycle();
        check("t4_full_write_swrite", snap_swr, 1);
        check("t4_full_write_w0", snap_w0, 0);
        cycle();
        check("t4_write_done", q0.size(), 0);

        // Stray return after a mid-burst reset: dropped, sticky error.
        do_reset();
        q0.push_back(mk_rd(25'h40));
        repeat (3) cycle();
        check("t5_model_pending", pend.size(), 1);
        do_reset();
        rdat = 16'hDEAD; rv = 1'b1; cycle();
        check("t5_rdv0", snap_rdv0, 0);
        check("t5_rdv1", snap_rdv1, 0);
        check("t5_err_same_cycle", snap_err, 0);
        cycle();
        check("t5_err_next", snap_err, 1);
        repeat (3) cycle();
        check("t5_err_sticky", snap_err, 1);
        do_reset();
        cycle();
        check("t5_err_cleared", snap_err, 0);

        // Stalled write keeps the grant until accepted.
        do_reset();
        sw = 1'b1;
        q0.push_back(mk_wr(25'h50, 16'h0505, 2'b11));
        q1.push_back(mk_wr(25'h60, 16'h0606, 2'b11));
        cycle();
        nbad = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (!(snap_swr && snap_addr == 25'h50 && snap_w0 && snap_w1)) nbad++;
        end
        check("t6_stall_cycles_bad", nbad, 0);
        sw = 1'b0;
        cycle();
        check("t6_accept_w0", snap_w0, 0);
        check("t6_accept_addr", snap_addr, 25'h50);
        cycle();
        cycle();
        check("t6_p1_addr", snap_addr, 25'h60);
        check("t6_p1_w1", snap_w1, 0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
